// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   localparam int unsigned DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : int'($clog2(w));
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock, LSB first, through a
// single full-adder cell. Optional signed-overflow output is enabled by
// defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned    CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_shift;
   logic [CW-1:0]    cnt;
   logic             carry_q;
   logic             fa_sum;
   logic             fa_carry;
   logic             accept;
   logic             last_bit;
   logic             busy_nxt;
   logic             done_nxt;

   assign accept   = (state == IDLE) && start;
   assign last_bit = (state == SHIFT) && (cnt == LAST);

   // New sum bit enters at the MSB so bit i ends at position i after WIDTH shifts.
   assign sum_shift = (sum_sr >> 1) | {fa_sum, {(WIDTH-1){1'b0}}};

   full_adder u_cell (
      .a     (opa[0]),
      .b     (opb[0]),
      .c     (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // FSM next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = SHIFT;
         SHIFT:   if (cnt == LAST) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // FSM output decode; done pulses on the cycle after the DONE state.
   always_comb begin
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      if (next_state != IDLE) busy_nxt = 1'b1;
      if (state == DONE)      done_nxt = 1'b1;
   end

   // Operand, carry, counter and partial-sum registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         opa     <= '0;
         opb     <= '0;
         sum_sr  <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
      end else if (accept) begin
         opa     <= a_in;
         opb     <= b_in;
         sum_sr  <= '0;
         carry_q <= cin;
         cnt     <= '0;
      end else if (state == SHIFT) begin
         opa     <= opa >> 1;
         opb     <= opb >> 1;
         sum_sr  <= sum_shift;
         carry_q <= fa_carry;
         cnt     <= cnt + CW'(1);
      end
   end

   // Registered outputs; result captured on the last SHIFT cycle and held.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         sum_out <= '0;
         cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         busy <= busy_nxt;
         done <= done_nxt;
         if (last_bit) begin
            sum_out <= sum_shift;
            cout    <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= carry_q ^ fa_carry;
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8); checks ovf when
// SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         clock;
   logic         reset;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_out;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int total = 0;
   int bad   = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .cin     (cin),
      .busy    (busy),
      .done    (done),
      .sum_out (sum_out),
      .cout    (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf     (ovf)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain unsigned sum of the operands and carry-in.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      int unsigned s;
      s = int'(a) + int'(b) + int'(ci);
      return (W+1)'(s);
   endfunction

   // Reference: two's-complement result out of range.
   function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      int sa, sb, r;
      sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
      r  = sa + sb + int'(ci);
      return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
   endfunction

   task automatic chk_result(input string tag, input logic [W-1:0] es, input logic eco, input logic eov);
      chk({tag, " sum"}, 32'(sum_out), 32'(es));
      chk({tag, " cout"}, 32'(cout), 32'(eco));
`ifdef SERIAL_ADDER_OVF_EN
      chk({tag, " ovf"}, 32'(ovf), 32'(eov));
`else
      if (eov === 1'bx) $display("unexpected x in expected ovf for %s", tag);
`endif
   endtask

   // One complete addition starting from IDLE with start pulsed for one edge.
   task automatic run_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic [W-1:0] es, input logic eco, input logic eov);
      int lat;
      int bc;
      a_in  = a;
      b_in  = b;
      cin   = ci;
      start = 1'b1;
      tick();
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      cin   = 1'($urandom);
      lat   = 0;
      bc    = 0;
      while (!done && lat < 30) begin
         if (busy) bc++;
         tick();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(W + 1));
      chk({tag, " busy cycles"}, 32'(bc), 32'(W + 1));
      chk_result(tag, es, eco, eov);
      tick();
      chk({tag, " done width"}, 32'(done), 32'(0));
      chk({tag, " sum held"}, 32'(sum_out), 32'(es));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int nd;
      int nb;
      logic [W:0] r;
      logic [W-1:0] ra, rb;
      logic rc;

      vecs[0] = '{a: 8'h35, b: 8'h4A, ci: 1'b0, s: 8'h7F, co: 1'b0, ov: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
      vecs[2] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, s: 8'hFF, co: 1'b1, ov: 1'b0};
      vecs[3] = '{a: 8'h7F, b: 8'h01, ci: 1'b0, s: 8'h80, co: 1'b0, ov: 1'b1};
      vecs[4] = '{a: 8'h80, b: 8'h80, ci: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b1};
      vecs[5] = '{a: 8'h10, b: 8'h20, ci: 1'b0, s: 8'h30, co: 1'b0, ov: 1'b0};
      vecs[6] = '{a: 8'h01, b: 8'h02, ci: 1'b0, s: 8'h03, co: 1'b0, ov: 1'b0};
      vecs[7] = '{a: 8'h00, b: 8'h00, ci: 1'b1, s: 8'h01, co: 1'b0, ov: 1'b0};
      vecs[8] = '{a: 8'hC0, b: 8'hC0, ci: 1'b0, s: 8'h80, co: 1'b1, ov: 1'b0};

      reset = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      cin   = 1'b0;
      tick();
      tick();
      chk("reset busy", 32'(busy), 32'(0));
      chk("reset done", 32'(done), 32'(0));
      chk_result("reset", 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      tick();

      // Directed table.
      for (int i = 0; i < 9; i++)
         run_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci,
                 vecs[i].s, vecs[i].co, vecs[i].ov);

      // Back-to-back with start held high.
      a_in  = 8'hFF;
      b_in  = 8'hFF;
      cin   = 1'b1;
      start = 1'b1;
      tick();
      a_in = 8'h00;
      b_in = 8'h00;
      cin  = 1'b0;
      lat  = 0;
      while (!done && lat < 30) begin
         tick();
         lat++;
      end
      chk("b2b first latency", 32'(lat), 32'(W + 1));
      chk_result("b2b first", 8'hFF, 1'b1, 1'b0);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!done && lat < 30);
      start = 1'b0;
      chk("b2b done spacing", 32'(lat), 32'(W + 2));
      chk_result("b2b second", 8'h00, 1'b0, 1'b0);
      tick();
      chk("b2b done width", 32'(done), 32'(0));
      repeat (3) tick();
      chk("b2b no third op", 32'(busy), 32'(0));

      // start pulse while busy must be ignored.
      a_in  = 8'h10;
      b_in  = 8'h20;
      cin   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      a_in  = 8'h11;
      b_in  = 8'h22;
      cin   = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat   = 4;
      while (!done && lat < 30) begin
         tick();
         lat++;
      end
      chk("busy start latency", 32'(lat), 32'(W + 1));
      chk_result("busy start", 8'h30, 1'b0, 1'b0);
      repeat (4) tick();
      chk("busy start not queued", 32'(busy), 32'(0));

      // Reset during an operation.
      a_in  = 8'hAA;
      b_in  = 8'h55;
      cin   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      #1;
      chk("midreset busy", 32'(busy), 32'(0));
      chk("midreset done", 32'(done), 32'(0));
      chk_result("midreset", 8'h00, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      nd = 0;
      nb = 0;
      repeat (20) begin
         tick();
         if (done) nd++;
         if (busy) nb++;
      end
      chk("post reset done count", 32'(nd), 32'(0));
      chk("post reset busy count", 32'(nb), 32'(0));
      run_add("after reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

      // Random operands against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         r  = ref_add(ra, rb, rc);
         run_add($sformatf("rnd%0d", i), ra, rb, rc, r[W-1:0], r[W], ref_ovf(ra, rb, rc));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
